// File: rtl/test_status_pkg.sv
// Shared types and constants for the self-checking program status monitor:
// state encoding, LED pattern helpers and parameter sanity limits.
package test_status_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_PASS   = 3'd3,
    ST_FAIL   = 3'd4,
    ST_TMO    = 3'd5
  } state_e;

  // LED helpers are built at the widest supported width and narrowed by the user.
  localparam int LED_MAX_W       = 64;
  localparam int MIN_NUM_CH      = 2;
  localparam int MIN_LED_W       = 2;
  localparam int MIN_STABLE_CYC  = 1;
  localparam int MIN_TIMEOUT_CYC = 2;
  localparam int MIN_BLINK_DIV   = 1;

  localparam logic [LED_MAX_W-1:0] LED_ALL_ONES = '1;

  function automatic bit cfg_ok(int num_ch, int led_w, int stable_cyc,
                                int timeout_cyc, int blink_div);
    return (num_ch >= MIN_NUM_CH) && (led_w >= MIN_LED_W) &&
           (led_w <= LED_MAX_W) && ((led_w % 2) == 0) &&
           (stable_cyc >= MIN_STABLE_CYC) && (timeout_cyc >= MIN_TIMEOUT_CYC) &&
           (blink_div >= MIN_BLINK_DIV);
  endfunction

  function automatic logic [LED_MAX_W-1:0] led_tmo_mask(int led_w);
    return (LED_MAX_W'(1) << (led_w / 2)) - LED_MAX_W'(1);
  endfunction

  function automatic logic [LED_MAX_W-1:0] led_fail_pat(logic phase);
    return phase ? {32{2'b10}} : {32{2'b01}};
  endfunction

endpackage

// File: rtl/test_status_monitor_led_pattern_gen.sv
// Blink divider, phase flop and LED pattern mux. Works on the next state so
// the pattern lands in the output register on the same edge as the state.
module led_pattern_gen
  import test_status_pkg::*;
#(
  parameter int LED_W     = 8,
  parameter int BLINK_DIV = 25000000
) (
  input  logic             clk,
  input  logic             rst,
  input  state_e           state_nxt,
  input  logic             state_chg,
  output logic [LED_W-1:0] led_o
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] WRAP = BW'(BLINK_DIV - 1);
  localparam logic [LED_MAX_W-1:0] TMO_MASK = led_tmo_mask(LED_W);

  logic [BW-1:0]    blink_cnt, cnt_nxt;
  logic             phase, phase_nxt;
  logic [LED_W-1:0] pat_nxt;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_nxt   = blink_cnt + BW'(1);
    phase_nxt = phase;
    if (state_chg) begin
      cnt_nxt   = '0;
      phase_nxt = 1'b0;
    end else if (blink_cnt == WRAP) begin
      cnt_nxt   = '0;
      phase_nxt = ~phase;
    end
  end

  always_comb begin
    pat_nxt = '0;
    case (state_nxt)
      ST_RUN, ST_SETTLE: pat_nxt = LED_W'(phase_nxt);
      ST_PASS:           pat_nxt = LED_W'(LED_ALL_ONES);
      ST_FAIL:           pat_nxt = LED_W'(led_fail_pat(phase_nxt));
      ST_TMO:            pat_nxt = LED_W'(TMO_MASK);
      default:           pat_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
      led_o     <= '0;
    end else begin
      blink_cnt <= cnt_nxt;
      phase     <= phase_nxt;
      led_o     <= pat_nxt;
    end
  end

endmodule

// File: rtl/test_status_monitor.sv
// Watches the core's done flag and result registers, decides PASS/FAIL/TIMEOUT,
// freezes the verdict with a cycle count and drives a status LED pattern.
module test_status_monitor
  import test_status_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int DATA_W      = 32,
  parameter int LED_W       = 8,
  parameter int STABLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int BLINK_DIV   = 25000000,
  parameter int AUTO_START  = 1,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     clear_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_i,
  input  logic [NUM_CH*DATA_W-1:0] match_val_i,
  input  logic [NUM_CH-1:0]        match_en_i,
  output logic                     busy_o,
  output logic                     pass_o,
  output logic                     fail_o,
  output logic                     timeout_o,
  output logic [CNT_W-1:0]         cycles_o,
  output logic [LED_W-1:0]         led_o
);

  if (!cfg_ok(NUM_CH, LED_W, STABLE_CYC, TIMEOUT_CYC, BLINK_DIV)) begin : g_bad_cfg
    $error("test_status_monitor: illegal parameter set");
  end

  localparam int STAB_W = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0]  TMO_LIMIT  = CNT_W'(TIMEOUT_CYC);
  localparam logic [STAB_W-1:0] STAB_LIMIT = STAB_W'(STABLE_CYC);

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cycle_cnt, cycle_nxt, cycle_inc;
  logic [STAB_W-1:0] stab_cnt, stab_nxt, stab_inc;
  logic              auto_pend;
  logic              done, all_match, verdict;
  logic              unused_ch0;

  assign done      = ch_data_i[0];
  assign cycle_inc = cycle_cnt + CNT_W'(1);
  assign stab_inc  = stab_cnt + STAB_W'(1);
  assign verdict   = done && (stab_inc == STAB_LIMIT);
  assign cycles_o  = cycle_cnt;

  // Channel 0 carries only the done flag; its other bits have no meaning here.
  assign unused_ch0 = ^{ch_data_i[DATA_W-1:0], match_val_i[DATA_W-1:0], match_en_i[0]};

  always_comb begin
    all_match = 1'b1;
    for (int i = 1; i < NUM_CH; i++) begin
      if (match_en_i[i] &&
          (ch_data_i[i*DATA_W +: DATA_W] != match_val_i[i*DATA_W +: DATA_W]))
        all_match = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    cycle_nxt = cycle_cnt;
    stab_nxt  = stab_cnt;
    if (clear_i) begin
      state_nxt = ST_IDLE;
      cycle_nxt = '0;
      stab_nxt  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i || auto_pend) begin
            state_nxt = ST_RUN;
            cycle_nxt = '0;
            stab_nxt  = '0;
          end
        end
        ST_RUN, ST_SETTLE: begin
          cycle_nxt = cycle_inc;
          // A verdict on the last allowed cycle beats the timeout.
          if (verdict) begin
            state_nxt = all_match ? ST_PASS : ST_FAIL;
          end else if (cycle_inc == TMO_LIMIT) begin
            state_nxt = ST_TMO;
          end else if (done) begin
            state_nxt = ST_SETTLE;
            stab_nxt  = stab_inc;
          end else begin
            state_nxt = ST_RUN;
            stab_nxt  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cycle_cnt <= '0;
      stab_cnt  <= '0;
      auto_pend <= (AUTO_START != 0);
      busy_o    <= 1'b0;
      pass_o    <= 1'b0;
      fail_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      cycle_cnt <= cycle_nxt;
      stab_cnt  <= stab_nxt;
      auto_pend <= 1'b0;
      busy_o    <= (state_nxt == ST_RUN) || (state_nxt == ST_SETTLE);
      pass_o    <= (state_nxt == ST_PASS);
      fail_o    <= (state_nxt == ST_FAIL);
      timeout_o <= (state_nxt == ST_TMO);
    end
  end

  led_pattern_gen #(
    .LED_W    (LED_W),
    .BLINK_DIV(BLINK_DIV)
  ) u_led (
    .clk      (clk),
    .rst      (rst),
    .state_nxt(state_nxt),
    .state_chg(state_nxt != state),
    .led_o    (led_o)
  );

endmodule

// File: tb/tb_test_status_monitor.sv
// Randomised scoreboard bench for test_status_monitor: stimulus pushes model
// verdicts into a queue, a negedge monitor pops them when a verdict appears.
module tb_test_status_monitor;

  localparam int NUM_CH      = 3;
  localparam int DATA_W      = 32;
  localparam int LED_W       = 8;
  localparam int STABLE_CYC  = 4;
  localparam int TIMEOUT_CYC = 100;
  localparam int BLINK_DIV   = 5;
  localparam int CNT_W       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [31:0] M1 = 32'h1;
  localparam logic [31:0] M2 = 32'hCAFE;

  typedef enum int {K_PASS, K_FAIL, K_TMO} kind_e;
  typedef struct {
    kind_e kind;
    int    cycles;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     start_i = 1'b0;
  logic                     clear_i = 1'b0;
  logic [NUM_CH*DATA_W-1:0] ch_data_i = '0;
  logic [NUM_CH*DATA_W-1:0] match_val_i = '0;
  logic [NUM_CH-1:0]        match_en_i = '0;
  logic                     busy_o, pass_o, fail_o, timeout_o;
  logic [CNT_W-1:0]         cycles_o;
  logic [LED_W-1:0]         led_o;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  logic        verdict_prev = 1'b0;
  logic [31:0] s_ch0[TIMEOUT_CYC];
  logic [31:0] s_c1[TIMEOUT_CYC];
  logic [31:0] s_c2[TIMEOUT_CYC];

  test_status_monitor #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .LED_W(LED_W), .STABLE_CYC(STABLE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC), .BLINK_DIV(BLINK_DIV), .AUTO_START(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .clear_i(clear_i),
    .ch_data_i(ch_data_i), .match_val_i(match_val_i), .match_en_i(match_en_i),
    .busy_o(busy_o), .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o),
    .cycles_o(cycles_o), .led_o(led_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] flags_of(kind_e k);
    case (k)
      K_PASS:  return 3'b100;
      K_FAIL:  return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic [7:0] verdict_led(kind_e k, int after);
    case (k)
      K_PASS:  return 8'hFF;
      K_TMO:   return 8'h0F;
      default: return (((after / BLINK_DIV) % 2) == 1) ? 8'hAA : 8'h55;
    endcase
  endfunction

  // Verdict = first sample ending a run of STABLE_CYC consecutive done highs,
  // judged on that sample's data; otherwise the run times out.
  function automatic exp_t model();
    exp_t e;
    int   run;
    run      = 0;
    e.kind   = K_TMO;
    e.cycles = TIMEOUT_CYC;
    for (int j = 0; j < TIMEOUT_CYC; j++) begin
      run = s_ch0[j][0] ? run + 1 : 0;
      if (run == STABLE_CYC) begin
        e.cycles = j + 1;
        e.kind = ((!match_en_i[1] || s_c1[j] == M1) && (!match_en_i[2] || s_c2[j] == M2))
                 ? K_PASS : K_FAIL;
        return e;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      verdict_prev = 1'b0;
    end else begin
      if ((pass_o || fail_o || timeout_o) && !verdict_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_verdict", 64'({pass_o, fail_o, timeout_o}), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("verdict_flags", 64'({pass_o, fail_o, timeout_o}), 64'(flags_of(mon_e.kind)));
          check("verdict_cycles", 64'(cycles_o), 64'(mon_e.cycles));
          check("verdict_led", 64'(led_o), 64'(verdict_led(mon_e.kind, 0)));
          check("verdict_busy", 64'(busy_o), 64'd0);
        end
      end
      verdict_prev = pass_o || fail_o || timeout_o;
    end
  end

  task automatic fill_quiet();
    for (int j = 0; j < TIMEOUT_CYC; j++) begin
      s_ch0[j] = 32'h0;
      s_c1[j]  = 32'h0;
      s_c2[j]  = 32'h0;
    end
  endtask

  task automatic set_high(input int from, input int to, input logic [31:0] c2);
    for (int j = from; j <= to; j++) begin
      s_ch0[j] = 32'h1;
      s_c1[j]  = M1;
      s_c2[j]  = c2;
    end
  endtask

  task automatic fill_random(input int p_done);
    for (int j = 0; j < TIMEOUT_CYC; j++) begin
      s_ch0[j] = ($urandom() & 32'hFFFF_FFFE) | 32'(($urandom_range(0, 99) < p_done) ? 1 : 0);
      s_c1[j]  = ($urandom_range(0, 1) == 1) ? M1 : $urandom();
      s_c2[j]  = ($urandom_range(0, 1) == 1) ? M2 : $urandom();
    end
  endtask

  // Entered at #1 after the edge that put the DUT into RUN with cycles_o=0.
  task automatic exec_run();
    exp_t e;
    bit   seen_hi;
    e = model();
    exp_q.push_back(e);
    seen_hi = 1'b0;
    for (int j = 0; j < e.cycles; j++) begin
      check("run_cycles", 64'(cycles_o), 64'(j));
      check("run_busy", 64'(busy_o), 64'd1);
      if (!seen_hi) check("run_blink", 64'(led_o), 64'((j / BLINK_DIV) % 2));
      ch_data_i = {s_c2[j], s_c1[j], s_ch0[j]};
      seen_hi   = seen_hi | s_ch0[j][0];
      tick();
    end
    for (int k = 0; k < 12; k++) begin
      check("hold_flags", 64'({pass_o, fail_o, timeout_o}), 64'(flags_of(e.kind)));
      check("hold_cycles", 64'(cycles_o), 64'(e.cycles));
      check("hold_led", 64'(led_o), 64'(verdict_led(e.kind, k)));
      ch_data_i = {$urandom(), $urandom(), $urandom()};
      start_i   = 1'($urandom_range(0, 1));
      tick();
    end
    start_i = 1'b0;
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_clear(input logic with_start);
    clear_i   = 1'b1;
    start_i   = with_start;
    ch_data_i = {M2, M1, 32'h1};
    tick();
    clear_i = 1'b0;
    start_i = 1'b0;
    check("clear_outputs", 64'({busy_o, pass_o, fail_o, timeout_o, cycles_o, led_o}), 64'd0);
    tick();
    check("idle_hold", 64'({busy_o, pass_o, fail_o, timeout_o, cycles_o, led_o}), 64'd0);
  endtask

  task automatic start_run();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  initial begin
    int p_tab[5] = '{0, 20, 40, 60, 80};
    match_val_i = {M2, M1, 32'hDEAD_BEEF};
    match_en_i  = 3'b110;
    #12;
    check("reset_outputs", 64'({busy_o, pass_o, fail_o, timeout_o, cycles_o, led_o}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    fill_quiet(); set_high(20, TIMEOUT_CYC - 1, M2);          exec_run(); do_clear(1'b0); start_run();
    fill_quiet(); set_high(20, TIMEOUT_CYC - 1, 32'hBEEF);    exec_run(); do_clear(1'b0); start_run();
    fill_quiet(); set_high(20, 22, M2); set_high(24, TIMEOUT_CYC - 1, M2);
    exec_run(); do_clear(1'b0); start_run();
    fill_quiet();                                             exec_run(); do_clear(1'b0); start_run();
    fill_quiet(); set_high(96, TIMEOUT_CYC - 1, M2);          exec_run(); do_clear(1'b1); start_run();

    // Drop reset while two done-high cycles sit in the stability counter.
    ch_data_i = {M2, M1, 32'h1};
    tick();
    tick();
    check("settle_busy", 64'(busy_o), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("async_reset_now", 64'({busy_o, pass_o, fail_o, timeout_o, cycles_o, led_o}), 64'd0);
    tick();
    check("async_reset_held", 64'({busy_o, pass_o, fail_o, timeout_o, cycles_o, led_o}), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    fill_quiet(); s_ch0[0] = 32'h1; s_ch0[1] = 32'h1; set_high(40, TIMEOUT_CYC - 1, M2);
    exec_run(); do_clear(1'b0); start_run();

    repeat (12) begin
      match_en_i = 3'($urandom_range(0, 7));
      fill_random(p_tab[$urandom_range(0, 4)]);
      exec_run();
      do_clear(1'($urandom_range(0, 1)));
      start_run();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
